// File: rtl/lal_seq_ctrl.sv
// lal_seq_ctrl: load/count/done sequencer with a registered compare flag.
// Optional LAL_SEQ_MATCH_STOP_EN: a registered match ends the count early, keeping cnt.
module lal_seq_ctrl #(
  parameter int CNT_W = 9,
  parameter int CMP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inhibit,
  input  logic [CMP_W-1:0] cmp_a,
  input  logic [CMP_W-1:0] cmp_b,
  input  logic             ack,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             match
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic match_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= (cmp_a == cmp_b);
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = COUNT;
        cnt_d   = load_val;
      end
      COUNT: if (!inhibit) begin
`ifdef LAL_SEQ_MATCH_STOP_EN
        if (match_q) state_d = DONE;
        else
`endif
        if (&cnt_q) begin
          state_d = DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign cnt   = cnt_q;
  assign busy  = (state_q == COUNT);
  assign done  = (state_q == DONE);
  assign match = match_q;
endmodule

// File: tb/tb_lal_seq_ctrl.sv
// tb_lal_seq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_lal_seq_ctrl;
  localparam int CNT_W = 9;
  localparam int CMP_W = 4;
  logic clk = 0, rst, start, inhibit, ack;
  logic [CNT_W-1:0] load_val;
  logic [CMP_W-1:0] cmp_a, cmp_b;
  logic [CNT_W-1:0] cnt;
  logic busy, done, match;
  int n_chk = 0, n_err = 0;
  int m_mode;
  logic [CNT_W-1:0] m_cnt;
  logic m_match;

  lal_seq_ctrl #(.CNT_W(CNT_W), .CMP_W(CMP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .inhibit(inhibit),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .ack(ack), .cnt(cnt), .busy(busy), .done(done), .match(match)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 counting, 2 done; cnt advances modulo 2^CNT_W.
  task automatic tick();
    int nm = m_mode;
    logic [CNT_W-1:0] nc = m_cnt;
    logic nmat = (cmp_a == cmp_b);
    bit stop = 0;
    if (m_mode == 0 && start) begin
      nm = 1;
      nc = load_val;
    end else if (m_mode == 1 && !inhibit) begin
`ifdef LAL_SEQ_MATCH_STOP_EN
      stop = m_match;
`endif
      if (stop) nm = 2;
      else begin
        nc = CNT_W'((int'(m_cnt) + 1) % (1 << CNT_W));
        if (int'(m_cnt) + 1 == (1 << CNT_W)) nm = 2;
      end
    end else if (m_mode == 2 && ack) nm = 0;
    @(posedge clk);
    #1;
    m_mode = nm;
    m_cnt = nc;
    m_match = nmat;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cnt = '0;
    m_match = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; inhibit = 0; ack = 0; load_val = '0; cmp_a = 4'h3; cmp_b = 4'h3;
    #3;
    n_chk++;
    if (cnt !== 0 || busy !== 0 || done !== 0 || match !== 0) begin
      n_err++;
      $display("FAIL reset_async: cnt=%h busy=%b done=%b match=%b, want all 0", cnt, busy, done, match);
    end
    @(posedge clk); #1;
    n_chk++;
    if (match !== 0) begin
      n_err++;
      $display("FAIL reset_match_held: match=%b want 0", match);
    end
    @(negedge clk);
    rst = 0; cmp_b = 4'h1; load_val = 9'h0AB;
    model_reset();
    tick();
    n_chk++;
    if (cnt !== 0 || busy !== 0 || done !== 0) begin
      n_err++;
      $display("FAIL reset_first_idle: cnt=%h busy=%b done=%b want 0/0/0", cnt, busy, done);
    end
  endtask

  task automatic test_count_done();
    load_val = 9'h1FC; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      logic [CNT_W-1:0] ec = (i < 4) ? CNT_W'(9'h1FC + i) : '0;
      n_chk++;
      if (cnt !== ec || done !== (i == 4) || busy !== (i < 4)) begin
        n_err++;
        $display("FAIL count_done[%0d]: cnt=%h done=%b busy=%b want %h/%b/%b", i, cnt, done, busy, ec, i == 4, i < 4);
      end
      if (i < 4) tick();
    end
    ack = 1;
    tick();
    ack = 0;
    n_chk++;
    if (done !== 0 || busy !== 0 || cnt !== 0) begin
      n_err++;
      $display("FAIL count_ack: done=%b busy=%b cnt=%h want 0/0/0", done, busy, cnt);
    end
  endtask

  task automatic test_inhibit();
    int n = 1;
    logic [CNT_W-1:0] prev;
    load_val = 9'h1F0; start = 1;
    tick();
    start = 0;
    prev = cnt;
    while (!done && n < 100) begin
      inhibit = (n >= 5 && n < 8);
      tick();
      n++;
      if (inhibit) begin
        n_chk++;
        if (cnt !== prev || busy !== 1) begin
          n_err++;
          $display("FAIL inhibit_freeze: cnt=%h busy=%b want %h/1", cnt, busy, prev);
        end
      end
      prev = cnt;
    end
    inhibit = 0;
    n_chk++;
    if (n !== 20) begin
      n_err++;
      $display("FAIL inhibit_done_edge: done at edge %0d want 20", n);
    end
    ack = 1;
    tick();
    ack = 0;
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    load_val = 9'h100; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    n_chk++;
    if (cnt !== 9'h105 || busy !== 1) begin
      n_err++;
      $display("FAIL reset_mid_pre: cnt=%h busy=%b want 105/1", cnt, busy);
    end
    #3 rst = 1;
    #1;
    n_chk++;
    if (cnt !== 0 || busy !== 0 || done !== 0) begin
      n_err++;
      $display("FAIL reset_mid_now: cnt=%h busy=%b done=%b want 0/0/0", cnt, busy, done);
    end
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 0 || busy !== 0) bad = 1;
    end
    n_chk++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_mid_after: done/busy rose after reset, want both 0");
    end
  endtask

  task automatic test_wrap_handshake();
    load_val = 9'h1FF; start = 1;
    tick();
    start = 0;
    n_chk++;
    if (busy !== 1 || cnt !== 9'h1FF) begin
      n_err++;
      $display("FAIL wrap_load: busy=%b cnt=%h want 1/1ff", busy, cnt);
    end
    tick();
    n_chk++;
    if (done !== 1 || cnt !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL wrap_done: done=%b cnt=%h busy=%b want 1/0/0", done, cnt, busy);
    end
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      tick();
      n_chk++;
      if (done !== 1 || cnt !== 0 || busy !== 0) begin
        n_err++;
        $display("FAIL hs_hold[%0d]: done=%b cnt=%h busy=%b want 1/0/0", i, done, cnt, busy);
      end
    end
    start = 1; ack = 1;
    tick();
    start = 0; ack = 0;
    n_chk++;
    if (done !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL hs_ack_start: done=%b busy=%b want 0/0", done, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (busy !== 0 || done !== 0) begin
        n_err++;
        $display("FAIL hs_no_latch[%0d]: busy=%b done=%b want 0/0", i, busy, done);
      end
    end
  endtask

  task automatic test_match();
    cmp_a = 4'hA; cmp_b = 4'hA;
    n_chk++;
    if (match !== 0) begin
      n_err++;
      $display("FAIL match_latency: match=%b want 0 before edge", match);
    end
    tick();
    n_chk++;
    if (match !== 1) begin
      n_err++;
      $display("FAIL match_eq: match=%b want 1", match);
    end
    cmp_b = 4'hB;
    tick();
    n_chk++;
    if (match !== 0) begin
      n_err++;
      $display("FAIL match_ne: match=%b want 0", match);
    end
`ifdef LAL_SEQ_MATCH_STOP_EN
    cmp_b = 4'hA;
    tick();
    load_val = 9'h010; start = 1;
    tick();
    start = 0;
    tick();
    n_chk++;
    if (done !== 1 || cnt !== 9'h010) begin
      n_err++;
      $display("FAIL match_stop: done=%b cnt=%h want 1/010", done, cnt);
    end
    repeat (2) tick();
    n_chk++;
    if (done !== 1 || cnt !== 9'h010) begin
      n_err++;
      $display("FAIL match_stop_hold: done=%b cnt=%h want 1/010", done, cnt);
    end
    ack = 1; cmp_b = 4'h1;
    tick();
    ack = 0;
`else
    cmp_b = 4'hA;
    tick();
    load_val = 9'h010; start = 1;
    tick();
    start = 0;
    tick();
    n_chk++;
    if (busy !== 1 || cnt !== 9'h011) begin
      n_err++;
      $display("FAIL match_status_only: busy=%b cnt=%h want 1/011", busy, cnt);
    end
    cmp_b = 4'h1;
    rst = 1; #1 rst = 0;
    model_reset();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(3) == 0);
      inhibit = ($urandom_range(3) == 0);
      ack = ($urandom_range(2) == 0);
      load_val = CNT_W'($urandom_range((1 << CNT_W) - 1, (1 << CNT_W) - 20));
      cmp_a = CMP_W'($urandom_range(3));
      cmp_b = CMP_W'($urandom_range(3));
      tick();
      n_chk++;
      if (cnt !== m_cnt || busy !== (m_mode == 1) || done !== (m_mode == 2) || match !== m_match) begin
        n_err++;
        $display("FAIL random[%0d]: cnt=%h busy=%b done=%b match=%b want %h/%b/%b/%b",
                 i, cnt, busy, done, match, m_cnt, m_mode == 1, m_mode == 2, m_match);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_done();
    test_inhibit();
    test_reset_mid();
    test_wrap_handshake();
    test_match();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lal_seq_ctrl.md
LAL_SEQ_CTRL -- requirements
Module: lal_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 9: counter width, legal range 2..16.
REQ-002 SHALL have parameter CMP_W, default 4: compare-operand width, legal range 1..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request to load and begin a count.
REQ-006 SHALL have port load_val, input, CNT_W: start value for the count.
REQ-007 SHALL have port inhibit, input, 1: freezes the counter while high.
REQ-008 SHALL have port cmp_a, input, CMP_W: compare operand A.
REQ-009 SHALL have port cmp_b, input, CMP_W: compare operand B.
REQ-010 SHALL have port ack, input, 1: consumer acknowledge of done.
REQ-011 SHALL have port cnt, output, CNT_W: registered counter value.
REQ-012 SHALL have port busy, output, 1: high in COUNT.
REQ-013 SHALL have port done, output, 1: high in DONE.
REQ-014 SHALL have port match, output, 1: registered (cmp_a == cmp_b).

Function
REQ-015 SHALL implement three states: IDLE, COUNT, DONE.
REQ-016 IDLE: start=1 SHALL load cnt<=load_val and enter COUNT next cycle; start=0 SHALL hold cnt.
REQ-017 COUNT, inhibit=0: SHALL increment cnt by 1 modulo 2^CNT_W each cycle.
REQ-018 COUNT, inhibit=1: SHALL hold cnt and state; inhibit SHALL take priority over increment.
REQ-019 COUNT: when cnt is all-ones and inhibit=0, SHALL wrap cnt to 0 and enter DONE in the same edge.
REQ-020 REQ-019 SHALL yield exactly 2^CNT_W - load_val increments between COUNT entry and DONE entry.
REQ-021 load_val all-ones SHALL reach DONE after one uninhibited COUNT cycle.
REQ-022 DONE: SHALL hold cnt=0 and done=1 until ack=1, then enter IDLE next edge.
REQ-023 ack SHALL be ignored outside DONE.
REQ-024 start SHALL be ignored in COUNT and DONE.
REQ-025 start and ack both high in DONE: SHALL go to IDLE only; start SHALL NOT be latched.
REQ-026 match SHALL update every cycle in every state, one cycle latency from cmp_a/cmp_b.
REQ-027 busy and done SHALL be decoded from registered state, never both high.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, cnt=0, busy=0, done=0, match=0, independent of clk.
REQ-029 rst asserted mid-COUNT or mid-DONE SHALL abandon the operation; no done pulse SHALL follow.
REQ-030 The first edge after rst deassertion SHALL behave as a normal IDLE cycle.

Configuration
REQ-031 Macro LAL_SEQ_MATCH_STOP_EN defined: in COUNT, registered match=1 with inhibit=0 SHALL move to DONE without incrementing, leaving cnt at its current value; DONE SHALL then hold that cnt, not 0, until ack.
REQ-032 Macro LAL_SEQ_MATCH_STOP_EN undefined: match SHALL be status only and SHALL NOT affect state or cnt.

Verification
REQ-033 Count to done: CNT_W=9, load_val=0x1FC, start pulse, inhibit=0 -> cnt 1FC,1FD,1FE,1FF then 0; done=1 on the 5th edge after start; ack -> IDLE next edge.
REQ-034 Inhibit: load 0x1F0, inhibit high for 3 cycles mid-count -> cnt frozen 3 cycles; done arrives exactly 3 cycles late.
REQ-035 Reset mid-count: assert rst between edges at cnt=0x105 -> cnt=0, busy=0 immediately; done never asserts.
REQ-036 Handshake corner: hold ack=0 for 10 cycles in DONE -> done stays 1; ack with start both high -> IDLE, then busy stays 0.
REQ-037 Match: cmp_a=cmp_b=0xA -> match=1 one cycle later; cmp_b=0xB -> match=0 one cycle later. With LAL_SEQ_MATCH_STOP_EN defined: load 0x010 with match high -> DONE holding cnt=0x010.
REQ-038 Wrap: load_val=0x1FF -> DONE after one COUNT cycle, cnt=0.
